imem_loader: RTL and testbench

Boot-time writer for the instruction memory of the single-cycle RISC-V core. It receives a framed program image as a byte stream, assembles little-endian 32-bit words and writes them to consecutive instruction-memory word locations from address 0. It holds the core in reset until a complete, checksum-verified image is loaded. It is the write-side counterpart of the instruction fetch path, which only reads the memory.

---
 rtl/imem_loader_if.sv | 20 ++
 rtl/imem_loader.sv | 134 +++++++++++++
 tb/tb_imem_loader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader uses the slave modport; the stream source and memory use the master modport.
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: parses a framed LE program image, writes
// words from address 0, and releases the core only after the checksum matches.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          reload,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_error
);

  typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, CSUM, DONE, ERROR} state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  state_t      state_reg, state_next;
  logic [15:0] n_reg, n_next;
  logic [15:0] word_idx_reg, word_idx_next;
  logic [1:0]  lane_reg, lane_next;
  logic [7:0]  sum_reg, sum_next;
  logic        mem_we_reg, mem_we_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;
  logic [7:0]  lane_byte_reg [3];
  logic [15:0] n_full;
  logic        accept;

  assign bus.rx_ready = (state_reg == HDR_LO) || (state_reg == HDR_HI) ||
                        (state_reg == DATA)   || (state_reg == CSUM);
  assign accept       = bus.rx_valid && bus.rx_ready;
  assign n_full       = {bus.rx_data, n_reg[7:0]};

  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign cpu_hold      = (state_reg != DONE);
  assign load_done     = (state_reg == DONE);
  assign load_error    = (state_reg == ERROR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= HDR_LO;
      n_reg         <= '0;
      word_idx_reg  <= '0;
      lane_reg      <= '0;
      sum_reg       <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      n_reg         <= n_next;
      word_idx_reg  <= word_idx_next;
      lane_reg      <= lane_next;
      sum_reg       <= sum_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  // Lanes 0..2 are buffered; lane 3 comes straight from rx_data into the write word.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (reset)
          lane_byte_reg[gi] <= '0;
        else if (accept && (state_reg == DATA) && (lane_reg == 2'(gi)))
          lane_byte_reg[gi] <= bus.rx_data;
      end
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    n_next         = n_reg;
    word_idx_next  = word_idx_reg;
    lane_next      = lane_reg;
    sum_next       = sum_reg;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;

    case (state_reg)
      HDR_LO: begin
        if (accept) begin
          n_next[7:0] = bus.rx_data;
          state_next  = HDR_HI;
        end
      end
      HDR_HI: begin
        if (accept) begin
          n_next[15:8] = bus.rx_data;
          if ((n_full == 16'd0) || ({1'b0, n_full} > MAX_WORDS)) begin
            state_next = ERROR;
          end else begin
            state_next    = DATA;
            word_idx_next = '0;
            lane_next     = '0;
            sum_next      = '0;
          end
        end
      end
      DATA: begin
        if (accept) begin
          sum_next  = sum_reg + bus.rx_data;
          lane_next = lane_reg + 2'd1;
          if (lane_reg == 2'd3) begin
            mem_we_next    = 1'b1;
            mem_addr_next  = {14'd0, word_idx_reg, 2'b00};
            mem_wdata_next = {bus.rx_data, lane_byte_reg[2], lane_byte_reg[1], lane_byte_reg[0]};
            word_idx_next  = word_idx_reg + 16'd1;
            if (word_idx_reg == n_reg - 16'd1)
              state_next = CSUM;
          end
        end
      end
      CSUM: begin
        if (accept)
          state_next = (bus.rx_data == sum_reg) ? DONE : ERROR;
      end
      DONE, ERROR: begin
        if (reload)
          state_next = HDR_LO;
      end
      default: state_next = HDR_LO;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected writes are queued as frames are
// driven and popped by a monitor whenever the loader strobes mem_we.
module tb_imem_loader;
  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic reset;
  logic reload;
  logic cpu_hold, load_done, load_error;

  imem_loader_if bus ();

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .reload     (reload),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int cycle = 0;
  int last_we_cycle = -100;
  int write_count = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Write monitor: every strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      write_count++;
      $display("write addr=0x%08h data=0x%08h", bus.mem_addr, bus.mem_wdata);
      check_val("we_spacing_ok", 32'(cycle - last_we_cycle >= 4), 32'd1);
      last_we_cycle = cycle;
      if (exp_addr_q.size() == 0) begin
        check_val("unexpected_write", 32'd1, 32'd0);
      end else begin
        check_val("mem_addr", bus.mem_addr, exp_addr_q.pop_front());
        check_val("mem_wdata", bus.mem_wdata, exp_data_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
    end
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'hxx;
  endtask

  task automatic send_frame(input byte_q_t bytes, input int max_gap);
    foreach (bytes[i]) send_byte(bytes[i], max_gap);
    go_idle();
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
    exp_addr_q.push_back(addr);
    exp_data_q.push_back(data);
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check_val("reload_cpu_hold", 32'(cpu_hold), 32'd1);
    check_val("reload_load_done", 32'(load_done), 32'd0);
    check_val("reload_load_error", 32'(load_error), 32'd0);
    check_val("reload_rx_ready", 32'(bus.rx_ready), 32'd1);
  endtask

  task automatic check_status(input string tag, input logic done, input logic err);
    check_val({tag, "_load_done"}, 32'(load_done), 32'(done));
    check_val({tag, "_load_error"}, 32'(load_error), 32'(err));
    check_val({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!done));
    check_val({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    check_val({tag, "_pending"}, 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
    check_val({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    check_val({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    check_val({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check_val({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check_val({tag, "_load_done"}, 32'(load_done), 32'd0);
    check_val({tag, "_load_error"}, 32'(load_error), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t nominal, bad_sum, reload_img, len0, len257, part;
    int wc;
    nominal    = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h33, 8'h81, 8'h10, 8'h00, 8'hA7};
    bad_sum    = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h33, 8'h81, 8'h10, 8'h00, 8'hA6};
    reload_img = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    len0       = '{8'h00, 8'h00};
    len257     = '{8'h01, 8'h01};
    part       = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reload = 1'b0;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    // Nominal load at full rate
    expect_write(32'h0, 32'h00500093);
    expect_write(32'h4, 32'h00108133);
    send_frame(nominal, 0);
    check_status("nominal", 1'b1, 1'b0);

    // Reload with a one-word image
    pulse_reload();
    expect_write(32'h0, 32'h00000013);
    send_frame(reload_img, 0);
    check_status("reload", 1'b1, 1'b0);

    // Checksum error: writes still happen
    pulse_reload();
    expect_write(32'h0, 32'h00500093);
    expect_write(32'h4, 32'h00108133);
    send_frame(bad_sum, 0);
    check_status("bad_csum", 1'b0, 1'b1);

    // Length zero and length above memory depth
    pulse_reload();
    wc = write_count;
    send_frame(len0, 0);
    check_status("len_zero", 1'b0, 1'b1);
    check_val("len_zero_writes", 32'(write_count - wc), 32'd0);

    pulse_reload();
    wc = write_count;
    send_frame(len257, 0);
    check_status("len_257", 1'b0, 1'b1);
    check_val("len_257_writes", 32'(write_count - wc), 32'd0);

    // Stalled stream with garbage during gaps
    pulse_reload();
    wc = write_count;
    expect_write(32'h0, 32'h00500093);
    expect_write(32'h4, 32'h00108133);
    send_frame(nominal, 5);
    check_status("stalled", 1'b1, 1'b0);
    check_val("stalled_writes", 32'(write_count - wc), 32'd2);

    // Reset after the 6th byte: word 0 was already complete, nothing after it
    pulse_reload();
    expect_write(32'h0, 32'h00500093);
    foreach (part[i]) send_byte(part[i], 0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("mid_reset");
    wc = write_count;
    expect_write(32'h0, 32'h00500093);
    expect_write(32'h4, 32'h00108133);
    send_frame(nominal, 0);
    check_status("after_reset", 1'b1, 1'b0);
    check_val("after_reset_writes", 32'(write_count - wc), 32'd2);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
